fft_frame_serializer: RTL

//  Drains a finished 256-point FFT frame as a stream of one complex sample per clock.
//  It owns the 5-bit block index that drives the scrambler mux, and registers the 8 lanes the mux returns.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_serializer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared widths, frame geometry and FSM encoding for the FFT frame serializer.
package fft_pkg;
  localparam int DW      = 20;
  localparam int LANES   = 8;
  localparam int LANE_W  = 56;
  localparam int NBLK    = 32;
  localparam int FRAME_N = LANES * NBLK;

  localparam int CW = $clog2(NBLK);
  localparam int LW = $clog2(LANES);
  localparam int IW = $clog2(FRAME_N);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t EMIT  = 2'd2;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;
endpackage

// File: rtl/fft_frame_serializer.sv
// Drains a 256-point FFT frame via scrambler_mux, one sample per clock over valid/ready.
// Latency: first sample 2 clocks after frame_start, 8 samples per 9 clocks; a stall holds every out_* stable.
module fft_frame_serializer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              flush,
  output logic [CW-1:0]     cycle,
  input  logic [LANE_W-1:0] lane_0,
  input  logic [LANE_W-1:0] lane_1,
  input  logic [LANE_W-1:0] lane_2,
  input  logic [LANE_W-1:0] lane_3,
  input  logic [LANE_W-1:0] lane_4,
  input  logic [LANE_W-1:0] lane_5,
  input  logic [LANE_W-1:0] lane_6,
  input  logic [LANE_W-1:0] lane_7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_real,
  output logic [DW-1:0]     out_imag,
  output logic [IW-1:0]     out_index,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  state_t        state_q, state_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic [LW-1:0] lane_idx_q, lane_idx_d;
  logic          frame_done_q, frame_done_d;
  sample_t       buf_q [LANES];
  sample_t       buf_d [LANES];
  logic [LANE_W-1:0] lane_in [LANES];
  logic          hs;

  assign lane_in[0] = lane_0;
  assign lane_in[1] = lane_1;
  assign lane_in[2] = lane_2;
  assign lane_in[3] = lane_3;
  assign lane_in[4] = lane_4;
  assign lane_in[5] = lane_5;
  assign lane_in[6] = lane_6;
  assign lane_in[7] = lane_7;

  // The mux carries 16 spare bits per lane that this block never looks at.
  logic lane_hi_unused;
  assign lane_hi_unused = ^{lane_0[LANE_W-1:2*DW], lane_1[LANE_W-1:2*DW],
                            lane_2[LANE_W-1:2*DW], lane_3[LANE_W-1:2*DW],
                            lane_4[LANE_W-1:2*DW], lane_5[LANE_W-1:2*DW],
                            lane_6[LANE_W-1:2*DW], lane_7[LANE_W-1:2*DW]};

  assign hs = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    lane_idx_d   = lane_idx_q;
    buf_d        = buf_q;
    frame_done_d = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      cycle_d    = '0;
      lane_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            cycle_d = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          for (int i = 0; i < LANES; i++) begin
            buf_d[i].re = lane_in[i][2*DW-1:DW];
            buf_d[i].im = lane_in[i][DW-1:0];
          end
          lane_idx_d = '0;
          state_d    = EMIT;
        end
        EMIT: begin
          if (hs) begin
            lane_idx_d = lane_idx_q + LW'(1);
            if (lane_idx_q == LW'(LANES - 1)) begin
              if (cycle_q == CW'(NBLK - 1)) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
              end else begin
                cycle_d = cycle_q + CW'(1);
                state_d = FETCH;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cycle_q      <= '0;
      lane_idx_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      lane_idx_q   <= lane_idx_d;
      frame_done_q <= frame_done_d;
      buf_q        <= buf_d;
    end
  end

  assign cycle      = cycle_q;
  assign out_valid  = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign out_real   = buf_q[lane_idx_q].re;
  assign out_imag   = buf_q[lane_idx_q].im;
  assign out_index  = {cycle_q, lane_idx_q};
  assign out_last   = out_valid & (out_index == IW'(FRAME_N - 1));

endmodule
